// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - stage-register bus between hazard unit/upstream stage and downstream stage
// Ports (signals):
//   stall, flush, valid_in, ctrl_in, data_in, cnt_clr    driven by master (hazard unit / upstream)
//   valid_out, ctrl_out, data_out, stall_cnt, kill_cnt   driven by slave (pipe_stage_reg)
interface pipe_stage_reg_if #(
  parameter int DATA_W = 271,
  parameter int CTRL_W = 13,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic              valid_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] data_in;
  logic              cnt_clr;
  logic              valid_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  kill_cnt;

  modport master (
    output stall, flush, valid_in, ctrl_in, data_in, cnt_clr,
    input  valid_out, ctrl_out, data_out, stall_cnt, kill_cnt
  );

  modport slave (
    input  stall, flush, valid_in, ctrl_in, data_in, cnt_clr,
    output valid_out, ctrl_out, data_out, stall_cnt, kill_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic pipeline stage register with stall, flush, bubble insertion and perf counters
// Ports:
//   clk  - clock, all state updates on rising edge
//   rst  - synchronous active-high reset
//   bus  - pipe_stage_reg_if.slave: stall/flush/valid_in/ctrl_in/data_in/cnt_clr in,
//          valid_out/ctrl_out/data_out/stall_cnt/kill_cnt out (all registered)
module pipe_stage_reg #(
  parameter int DATA_W     = 271,
  parameter int CTRL_W     = 13,
  parameter bit FLUSH_DATA = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  pipe_stage_reg_if.slave bus
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  kill_cnt_q;

  logic load_en;
  logic data_en;
  logic stall_inc;
  logic kill_inc;

  // Flush outranks stall, so a load only happens when neither is asserted.
  assign load_en = !bus.flush && !bus.stall;
  // The data bundle is only touched by a flush when it is configured to clear.
  assign data_en = load_en || (bus.flush && FLUSH_DATA);

  // Only real instructions are counted; bubbles held or killed are free.
  assign stall_inc = bus.stall && !bus.flush && valid_q;
  assign kill_inc  = bus.flush && valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      if (bus.flush) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
      end else if (load_en) begin
        valid_q <= bus.valid_in;
        // An invalid upstream slot enters as a bubble with zero control.
        ctrl_q  <= bus.valid_in ? bus.ctrl_in : '0;
      end
      if (data_en) begin
        data_q <= bus.flush ? '0 : bus.data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (kill_inc && (kill_cnt_q != {CNT_W{1'b1}})) begin
        kill_cnt_q <= kill_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.ctrl_out  = ctrl_q;
  assign bus.data_out  = data_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.kill_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg (FLUSH_DATA=0/CNT_W=16 and FLUSH_DATA=1/CNT_W=4)
module tb_pipe_stage_reg;
  localparam int DW = 271;
  localparam int CW = 13;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) b0 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4))  b1 ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_DATA(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_DATA(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  logic [DW-1:0] d1, d2, d3, d4, ones;

  task automatic drive(input logic st, input logic fl, input logic vi,
                       input logic [CW-1:0] ci, input logic [DW-1:0] di, input logic cc);
    b0.stall = st; b0.flush = fl; b0.valid_in = vi; b0.ctrl_in = ci; b0.data_in = di; b0.cnt_clr = cc;
    b1.stall = st; b1.flush = fl; b1.valid_in = vi; b1.ctrl_in = ci; b1.data_in = di; b1.cnt_clr = cc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pipeline registers of both instances against one expectation (data may differ).
  task automatic chk_pipe(input string tag, input logic v, input logic [CW-1:0] c,
                          input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    chk({tag, " valid0"}, DW'(b0.valid_out), DW'(v));
    chk({tag, " ctrl0"},  DW'(b0.ctrl_out),  DW'(c));
    chk({tag, " data0"},  b0.data_out,       e0);
    chk({tag, " valid1"}, DW'(b1.valid_out), DW'(v));
    chk({tag, " ctrl1"},  DW'(b1.ctrl_out),  DW'(c));
    chk({tag, " data1"},  b1.data_out,       e1);
  endtask

  task automatic chk_cnt(input string tag, input int s0, input int k0, input int s1, input int k1);
    chk({tag, " stall_cnt0"}, DW'(b0.stall_cnt), DW'(s0));
    chk({tag, " kill_cnt0"},  DW'(b0.kill_cnt),  DW'(k0));
    chk({tag, " stall_cnt1"}, DW'(b1.stall_cnt), DW'(s1));
    chk({tag, " kill_cnt1"},  DW'(b1.kill_cnt),  DW'(k1));
  endtask

  initial begin
    ones = '1;
    d1 = '0; d1[DW-1 -: 8] = 8'hC3; d1[15:0] = 16'h1234;
    d2 = '0; d2[200 +: 16] = 16'hBEEF; d2[15:0] = 16'h5678;
    d3 = '0; d3[100 +: 16] = 16'hCAFE; d3[15:0] = 16'h9ABC;
    d4 = '0; d4[DW-1 -: 4] = 4'h9; d4[15:0] = 16'h0F0F;

    // Reset dominates every other input.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 13'h1FFF, ones, 1'b0);
    step();
    chk_pipe("reset", 1'b0, '0, '0, '0);
    chk_cnt("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // Load a valid slot, then an invalid one becomes a zero-control bubble.
    drive(1'b0, 1'b0, 1'b1, 13'h0A5, d1, 1'b0);
    step();
    chk_pipe("load", 1'b1, 13'h0A5, d1, d1);
    drive(1'b0, 1'b0, 1'b0, 13'h1FFF, d2, 1'b0);
    step();
    chk_pipe("bubble", 1'b0, '0, d2, d2);

    // Stall a valid slot for 3 cycles while upstream presents new values.
    drive(1'b0, 1'b0, 1'b1, 13'h123, d3, 1'b0);
    step();
    chk_pipe("load2", 1'b1, 13'h123, d3, d3);
    drive(1'b1, 1'b0, 1'b1, 13'h055, d4, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_pipe("stall", 1'b1, 13'h123, d3, d3);
      chk_cnt("stall", i, 0, i, 0);
    end
    drive(1'b0, 1'b0, 1'b1, 13'h055, d4, 1'b0);
    step();
    chk_pipe("unstall", 1'b1, 13'h055, d4, d4);
    chk_cnt("unstall", 3, 0, 3, 0);

    // Flush with simultaneous stall on a valid slot.
    drive(1'b1, 1'b1, 1'b1, 13'h0AA, d1, 1'b0);
    step();
    chk_pipe("flush", 1'b0, '0, d4, '0);
    chk_cnt("flush", 3, 1, 3, 1);
    // Flushing the resulting bubble is not counted.
    drive(1'b0, 1'b1, 1'b1, 13'h0AA, d1, 1'b0);
    step();
    chk_pipe("flush2", 1'b0, '0, d4, '0);
    chk_cnt("flush2", 3, 1, 3, 1);

    // Saturation: 20 stalled cycles on a valid slot (CNT_W=4 instance tops out at 15).
    drive(1'b0, 1'b0, 1'b1, 13'h0F0, d1, 1'b0);
    step();
    chk_pipe("load3", 1'b1, 13'h0F0, d1, d1);
    drive(1'b1, 1'b0, 1'b0, 13'h1FFF, d2, 1'b0);
    repeat (20) step();
    chk_pipe("sat", 1'b1, 13'h0F0, d1, d1);
    chk_cnt("sat", 23, 1, 15, 1);
    step();
    chk_cnt("sat_hold", 24, 1, 15, 1);

    // Counter clear during a stall leaves the pipeline registers alone.
    drive(1'b1, 1'b0, 1'b0, 13'h1FFF, d2, 1'b1);
    step();
    chk_pipe("clr", 1'b1, 13'h0F0, d1, d1);
    chk_cnt("clr", 0, 0, 0, 0);

    // Reset in the middle of a stall.
    drive(1'b1, 1'b0, 1'b0, 13'h1FFF, d2, 1'b0);
    repeat (5) step();
    chk_cnt("stall5", 5, 0, 5, 0);
    rst = 1'b1;
    step();
    chk_pipe("rst_mid", 1'b0, '0, '0, '0);
    chk_cnt("rst_mid", 0, 0, 0, 0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 13'h1AB, d2, 1'b0);
    step();
    chk_pipe("post_rst", 1'b1, 13'h1AB, d2, d2);

    // A stalled bubble is not counted.
    drive(1'b0, 1'b0, 1'b0, 13'h1FFF, d3, 1'b0);
    step();
    chk_pipe("bubble2", 1'b0, '0, d3, d3);
    drive(1'b1, 1'b0, 1'b1, 13'h077, d4, 1'b0);
    repeat (2) step();
    chk_pipe("stall_bubble", 1'b0, '0, d3, d3);
    chk_cnt("stall_bubble", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the pipelined CPU. It is the generic successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage carries a valid tag, a control bundle and a data bundle. The block adds:
- stall (hold) and flush (bubble) with a defined priority;
- bubble insertion when upstream delivers an invalid slot;
- a FLUSH_DATA mode that also clears data on a flush;
- saturating stall and kill performance counters.

It sits between two adjacent stages and is driven by the hazard unit.

## Interface
Parameters:
- DATA_W, 271, width of data bundle (ID/EX: RD1, RD2, PC, sign-ext, Rn, Rm, Rd).
- CTRL_W, 13, width of control bundle (EX+M+WB control fields).
- FLUSH_DATA, 0, 1 = flush also clears data_out; 0 = data_out holds on flush.
- CNT_W, 16, width of each performance counter.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, reset, synchronous, active-high.
- stall, input, 1, hold current contents (hazard unit, load-use or memory wait).
- flush, input, 1, kill current slot (branch taken or exception).
- valid_in, input, 1, upstream slot holds a real instruction.
- ctrl_in, input, CTRL_W, control bundle from upstream.
- data_in, input, DATA_W, data bundle from upstream.
- cnt_clr, input, 1, synchronous clear of both counters.
- valid_out, output, 1, registered valid tag.
- ctrl_out, output, CTRL_W, registered control; always 0 when valid_out=0.
- data_out, output, DATA_W, registered data.
- stall_cnt, output, CNT_W, cycles a valid instruction was held.
- kill_cnt, output, CNT_W, valid instructions removed by flush.

## Operation
- Register update priority per cycle: rst > flush > stall > load.
- rst: valid_out=0, ctrl_out=0, data_out=0, stall_cnt=0, kill_cnt=0.
- flush (rst=0):
  - valid_out←0, ctrl_out←0.
  - data_out←0 if FLUSH_DATA=1, else data_out holds.
  - A flush overrides a simultaneous stall.
- stall (rst=0, flush=0): valid_out, ctrl_out and data_out all hold.
- load (rst=0, flush=0, stall=0):
  - valid_out←valid_in and data_out←data_in.
  - ctrl_out←(valid_in ? ctrl_in : 0), so an invalid upstream slot enters as a bubble with zero control. Zero control means no MemWrite, no RegWrite, no branch.
- Invariant: valid_out=0 implies ctrl_out=0 in every cycle.
- stall_cnt rules:
  - Increments when stall=1, flush=0 and valid_out=1.
  - Saturates at 2^CNT_W−1.
  - A stalled bubble is not counted.
- kill_cnt rules:
  - Increments when flush=1 and valid_out=1.
  - Saturates at 2^CNT_W−1.
  - A flushed bubble is not counted.
- Counter priority: rst > cnt_clr > increment. cnt_clr has no effect on the pipeline registers.
- Implementation: all datapath bits as per-bit enabled flops with the common enable derived from the priority above. No latches.
- Nothing is sampled on a rejected (stalled) load; upstream holds its own values.

## Timing
- Latency: 1 cycle from data_in/ctrl_in/valid_in to outputs on a load.
- Flush takes effect at the edge where flush=1. The slot is a bubble from the next cycle on. A flushed slot is never re-exposed.
- Stall held for N cycles:
  - Outputs constant for N cycles.
  - Next load happens at the first edge with stall=0.
  - stall_cnt rises by N if valid_out=1 throughout.
- Reset mid-stall or mid-flush: outputs and counters are 0 on the next cycle regardless of other inputs.
- Counter at saturation stays at all-ones until rst or cnt_clr. There is no wrap-around.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- **Reset:** rst=1 with stall=1, flush=1, valid_in=1, ctrl_in=0x1FFF, data_in all-ones → next cycle every output and counter is 0.
- **Load and bubble:**
  - valid_in=1, ctrl_in=0x0A5, data_in=0x…1234 → next cycle valid_out=1, ctrl_out=0x0A5, data_out=0x…1234.
  - Then valid_in=0, ctrl_in=0x1FFF → valid_out=0, ctrl_out=0, data_out=data_in.
- **Stall 3 cycles on valid slot:** outputs unchanged for 3 cycles; stall_cnt 0→3; new data_in is loaded on the edge after stall drops.
- **Flush vs stall, both FLUSH_DATA settings:**
  - Flush=1 and stall=1 together on a valid slot → valid_out=0, ctrl_out=0, kill_cnt=1, stall_cnt unchanged.
  - data_out holds with FLUSH_DATA=0 and becomes 0 with FLUSH_DATA=1.
  - A second flush on the resulting bubble leaves kill_cnt=1.
- **Counter saturation and clear:**
  - With CNT_W=4, stall a valid slot 20 cycles → stall_cnt=15 and stays 15.
  - cnt_clr=1 with stall=1 → stall_cnt=0 next cycle while outputs still hold.
- **Reset mid-stall:** stall=1 on a valid slot, stall_cnt=5, assert rst for one cycle → all outputs and counters 0. The following cycle loads data_in normally when stall=0.
